// File: rtl/cache_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_if
// Block-level miss/memory bus used on every port of the cache memory arbiter.
// One instance per cache requester and one for the shared memory side.
//   read   block read request (level, held until ready)
//   write  block write request (level, held until ready)
//   addr   block address (word address without the 2 offset bits)
//   wdata  write block
//   ready  one-cycle completion strobe
//   rdata  read block, valid with ready
// master: drives the request (a cache, or the arbiter toward memory)
// slave : answers the request (the arbiter toward a cache, or memory)
// -----------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (output read, write, addr, wdata, input ready, rdata);
    modport slave  (input read, write, addr, wdata, output ready, rdata);
endinterface

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
// Shares the single block-wide memory port between the I-cache (m0) and the
// D-cache (m1). One requester owns the port at a time; ties are broken
// round-robin. A dirty write-back followed by its refill stays under a single
// grant so the other cache cannot interleave.
// Ports:
//   clk           clock, all state on rising edge
//   proc_reset_n  asynchronous active-low reset
//   m0            I-cache requester port (arbiter is the slave)
//   m1            D-cache requester port (arbiter is the slave)
//   mem           external memory port (arbiter is the master)
// Requests, address and data pass through combinationally while granted;
// nothing is buffered or modified. rdata is broadcast to both caches and only
// the one seeing ready consumes it.
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic                 clk,
    input  logic                 proc_reset_n,
    cache_mem_arbiter_if.slave   m0,
    cache_mem_arbiter_if.slave   m1,
    cache_mem_arbiter_if.master  mem
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t state, state_nxt;
    logic   last, last_nxt;        // most recently granted requester
    logic   wb_lock, wb_lock_nxt;  // write-back done, refill still owed

    // Requester ports gathered into index-able vectors.
    logic [1:0]             rd, wr, req;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata;

    assign rd    = {m1.read,  m0.read};
    assign wr    = {m1.write, m0.write};
    assign req   = rd | wr;
    assign addr  = {m1.addr,  m0.addr};
    assign wdata = {m1.wdata, m0.wdata};

    logic busy, own;
    assign busy = (state != IDLE);
    assign own  = (state == GRANT1);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state   <= IDLE;
            last    <= 1'b1;      // m0 wins the first tie
            wb_lock <= 1'b0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            wb_lock <= wb_lock_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        wb_lock_nxt = wb_lock;
        case (state)
            IDLE: begin
                wb_lock_nxt = 1'b0;
                // On a tie the requester that was not served last goes first.
                if (req[0] && (!req[1] || last)) begin
                    state_nxt = GRANT0;
                    last_nxt  = 1'b0;
                end else if (req[1]) begin
                    state_nxt = GRANT1;
                    last_nxt  = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                // On the completion cycle the cache drops its request
                // combinationally, so only the write flag decides here:
                // a finished write-back keeps the grant for the refill.
                if (mem.ready) begin
                    if (wr[own]) begin
                        wb_lock_nxt = 1'b1;
                    end else begin
                        state_nxt   = IDLE;
                        wb_lock_nxt = 1'b0;
                    end
                end else if (!req[own]) begin
                    // Abandoned request, or cache done after the locked pair.
                    state_nxt   = IDLE;
                    wb_lock_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                wb_lock_nxt = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Forwarding. All outputs decode from state, so an asynchronous reset
    // forces them low at once.
    // -------------------------------------------------------------------------
    logic              mem_read_c, mem_write_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [1:0]        rdy_c;

    always_comb begin
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        rdy_c       = 2'b00;
        if (busy) begin
            mem_read_c  = rd[own];
            mem_write_c = wr[own];
            mem_addr_c  = addr[own];
            mem_wdata_c = wdata[own];
            rdy_c[own]  = mem.ready;
        end
    end

    assign mem.read  = mem_read_c;
    assign mem.write = mem_write_c;
    assign mem.addr  = mem_addr_c;
    assign mem.wdata = mem_wdata_c;
    assign m0.ready  = rdy_c[0];
    assign m1.ready  = rdy_c[1];
    assign m0.rdata  = mem.rdata;
    assign m1.rdata  = mem.rdata;

    // The lock flag can only be held while a grant is active.
    always_ff @(posedge clk) begin
        if (proc_reset_n && wb_lock) assert (state != IDLE);
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int VW = 2 + AW + DW + 2 + 2 * DW;

    localparam logic [AW-1:0] A0  = 28'h0000010;
    localparam logic [DW-1:0] WD0 = {4{32'h0C0FFEE0}};
    localparam logic [DW-1:0] WD1 = {4{32'hD1D1D1D1}};
    localparam logic [DW-1:0] RDA = {16{8'hA5}};

    logic clk = 1'b0;
    logic proc_reset_n = 1'b0;

    cache_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    cache_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
    cache_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .m0           (m0_if),
        .m1           (m1_if),
        .mem          (mem_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] obs();
        return {mem_if.read, mem_if.write, mem_if.addr, mem_if.wdata,
                m0_if.ready, m1_if.ready, m0_if.rdata, m1_if.rdata};
    endfunction

    // Expected outputs for a given owner (-1 = nobody) from current inputs.
    function automatic logic [VW-1:0] exp_vec(input int own);
        if (own == 0)
            return {m0_if.read, m0_if.write, m0_if.addr, m0_if.wdata,
                    mem_if.ready, 1'b0, mem_if.rdata, mem_if.rdata};
        else if (own == 1)
            return {m1_if.read, m1_if.write, m1_if.addr, m1_if.wdata,
                    1'b0, mem_if.ready, mem_if.rdata, mem_if.rdata};
        else
            return {2'b00, {AW{1'b0}}, {DW{1'b0}}, 2'b00, mem_if.rdata, mem_if.rdata};
    endfunction

    task automatic set_in(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          input logic mrdy, input logic [DW-1:0] mrd);
        m0_if.read = r0; m0_if.write = w0; m0_if.addr = a0; m0_if.wdata = d0;
        m1_if.read = r1; m1_if.write = w1; m1_if.addr = a1; m1_if.wdata = d1;
        mem_if.ready = mrdy; mem_if.rdata = mrd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        proc_reset_n = 1'b0;
        set_in(0, 0, '0, '0, 0, 0, '0, '0, 0, RDA);
        @(negedge clk);
        #2 proc_reset_n = 1'b1;
    endtask

    // Directed table: one row per clock cycle, starting right after reset.
    typedef struct {
        logic          r0, w0, r1, w1, mrdy;
        logic [AW-1:0] a1;
        int            own;
        logic          erd, ewr, er0, er1;
    } vec_t;

    function automatic vec_t mk(input logic r0, w0, r1, w1, mrdy, input logic [AW-1:0] a1,
                                input int own, input logic erd, ewr, er0, er1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.mrdy = mrdy; v.a1 = a1;
        v.own = own; v.erd = erd; v.ewr = ewr; v.er0 = er0; v.er1 = er1;
        return v;
    endfunction

    // Reference model: who owns the memory port and who was served last.
    int m_own;
    int m_last;

    task automatic model_step();
        logic [1:0] rq, wq;
        logic       mrdy;
        rq   = {m1_if.read, m0_if.read};
        wq   = {m1_if.write, m0_if.write};
        mrdy = mem_if.ready;
        if (m_own < 0) begin
            if ((rq[0] | wq[0]) && (rq[1] | wq[1])) m_own = 1 - m_last;
            else if (rq[0] | wq[0])                 m_own = 0;
            else if (rq[1] | wq[1])                 m_own = 1;
            if (m_own >= 0) m_last = m_own;
        end else if (mrdy) begin
            if (!wq[m_own]) m_own = -1;            // write-back keeps the grant
        end else if (!(rq[m_own] | wq[m_own])) begin
            m_own = -1;
        end
    endtask

    initial begin
        vec_t           tbl[23];
        logic [AW-1:0]  ea;
        logic [DW-1:0]  ed;
        logic [1:0]     exp_rdy;
        logic [AW-1:0]  a1v;
        logic [DW-1:0]  mrd;
        int             k0, k1;

        set_in(0, 0, '0, '0, 0, 0, '0, '0, 0, RDA);

        // ---------------- reset state: outputs low despite active inputs
        #3;
        set_in(1, 0, A0, WD0, 1, 0, 28'h24, WD1, 1, RDA);
        #1 chk("reset_outputs", obs(), exp_vec(-1));
        @(negedge clk);
        #1 chk("reset_held_over_edge", obs(), exp_vec(-1));
        set_in(0, 0, '0, '0, 0, 0, '0, '0, 0, RDA);
        #1 proc_reset_n = 1'b1;

        // ---------------- directed table
        tbl[0]  = mk(1,0,0,0,0, 28'h24,  -1, 0,0,0,0);   // single read requested
        tbl[1]  = mk(1,0,0,0,0, 28'h24,   0, 1,0,0,0);
        tbl[2]  = mk(1,0,0,0,1, 28'h24,   0, 1,0,1,0);   // completion
        tbl[3]  = mk(0,0,0,0,0, 28'h24,  -1, 0,0,0,0);
        tbl[4]  = mk(0,0,0,0,1, 28'h24,  -1, 0,0,0,0);   // stray ready in idle
        tbl[5]  = mk(1,0,1,0,0, 28'h24,  -1, 0,0,0,0);   // tie, m0 served last
        tbl[6]  = mk(1,0,1,0,0, 28'h24,   1, 1,0,0,0);
        tbl[7]  = mk(1,0,1,0,1, 28'h24,   1, 1,0,0,1);
        tbl[8]  = mk(1,0,0,0,0, 28'h24,  -1, 0,0,0,0);
        tbl[9]  = mk(1,0,0,0,1, 28'h24,   0, 1,0,1,0);
        tbl[10] = mk(1,0,0,1,0, 28'h24,  -1, 0,0,0,0);   // m1 write-back, m0 pending
        tbl[11] = mk(1,0,0,1,0, 28'h24,   1, 0,1,0,0);
        tbl[12] = mk(1,0,0,1,1, 28'h24,   1, 0,1,0,1);
        tbl[13] = mk(1,0,1,0,0, 28'h124,  1, 1,0,0,0);   // refill, no idle gap
        tbl[14] = mk(1,0,1,0,1, 28'h124,  1, 1,0,0,1);
        tbl[15] = mk(1,0,0,0,0, 28'h124, -1, 0,0,0,0);
        tbl[16] = mk(1,0,0,0,1, 28'h124,  0, 1,0,1,0);
        tbl[17] = mk(1,0,0,0,0, 28'h24,  -1, 0,0,0,0);   // abandon
        tbl[18] = mk(1,0,1,0,0, 28'h24,   0, 1,0,0,0);
        tbl[19] = mk(0,0,1,0,0, 28'h24,   0, 0,0,0,0);
        tbl[20] = mk(0,0,1,0,0, 28'h24,  -1, 0,0,0,0);
        tbl[21] = mk(0,0,1,0,1, 28'h124,  1, 1,0,0,1);
        tbl[22] = mk(0,0,0,0,0, 28'h24,  -1, 0,0,0,0);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            set_in(tbl[i].r0, tbl[i].w0, A0, WD0, tbl[i].r1, tbl[i].w1, tbl[i].a1, WD1,
                   tbl[i].mrdy, RDA);
            ea = (tbl[i].own == 0) ? A0  : (tbl[i].own == 1) ? tbl[i].a1 : '0;
            ed = (tbl[i].own == 0) ? WD0 : (tbl[i].own == 1) ? WD1       : '0;
            #1 chk($sformatf("table_row%0d", i), obs(),
                   {tbl[i].erd, tbl[i].ewr, ea, ed, tbl[i].er0, tbl[i].er1, RDA, RDA});
        end

        // ---------------- tie after reset: m0, m1, m0
        do_reset();
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            set_in(1, 0, A0, WD0, 1, 0, 28'h24, WD1, 0, RDA);
            #1 chk($sformatf("tie_idle%0d", r), VW'({mem_if.read, m0_if.ready, m1_if.ready}), VW'(3'b000));
            @(negedge clk);
            mem_if.ready = 1'b1;
            exp_rdy = (r % 2 == 0) ? 2'b10 : 2'b01;
            ea      = (r % 2 == 0) ? A0 : 28'h24;
            #1 chk($sformatf("tie_round%0d", r), VW'({m0_if.ready, m1_if.ready, mem_if.addr}),
                   VW'({exp_rdy, ea}));
        end

        // ---------------- async reset in the middle of an m1 read
        @(negedge clk);
        set_in(0, 0, A0, WD0, 1, 0, 28'h0000024, WD1, 0, RDA);
        @(negedge clk);
        mem_if.ready = 1'b1;
        #1 chk("arst_before", VW'({mem_if.read, m1_if.ready}), VW'(2'b11));
        #1 proc_reset_n = 1'b0;
        #1 chk("arst_immediate", obs(), exp_vec(-1));
        mem_if.ready = 1'b0;
        #1 proc_reset_n = 1'b1;
        #0 chk("arst_release_idle", VW'(mem_if.read), VW'(1'b0));
        @(negedge clk);
        #1 chk("arst_regrant", VW'({mem_if.read, mem_if.addr}), VW'({1'b1, 28'h0000024}));

        // ---------------- randomized against the reference model
        do_reset();
        m_own  = -1;
        m_last = 1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            k0  = $urandom_range(0, 9);
            k1  = $urandom_range(0, 9);
            a1v = AW'($urandom);
            mrd = {$urandom, $urandom, $urandom, $urandom};
            set_in(k0 inside {[4:6], 9}, k0 inside {[7:9]}, AW'($urandom), {$urandom, $urandom, $urandom, $urandom},
                   k1 inside {[4:6], 9}, k1 inside {[7:9]}, a1v, {$urandom, $urandom, $urandom, $urandom},
                   ($urandom_range(0, 9) < 3), mrd);
            #1 chk($sformatf("rand_cycle%0d", c), obs(), exp_vec(m_own));
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
